// File: rtl/fft_seq_control.sv
// Multi-stage radix-2 FFT sequencer: walks every stage over four banks,
// issuing reads, mux selects and twiddle indices, with a delayed write side.
module fft_seq_control #(
  parameter int unsigned NUMSTAGES = 5,
  parameter int unsigned PIPE      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         inverse,
  input  logic                         hold,
  output logic                         busy,
  output logic                         done,
  output logic                         stage_done,
  output logic [3:0]                   stage_num,
  output logic                         conj_en,
  output logic                         rd_en,
  output logic [4*(NUMSTAGES-2)-1:0]   rd_addr,
  output logic                         wr_en,
  output logic [4*(NUMSTAGES-2)-1:0]   wr_addr,
  output logic                         m0_s,
  output logic [1:0]                   m1_s,
  output logic                         m2_s,
  output logic                         m3_s,
  output logic [NUMSTAGES-2:0]         tw_idx
);

  localparam int unsigned W   = NUMSTAGES - 2;
  localparam int unsigned TWW = NUMSTAGES - 1;
  localparam int unsigned DW  = W + 2;
  localparam int unsigned DCW = (PIPE > 1) ? $clog2(PIPE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_cnt;
  logic [DCW-1:0]  r_drain;
  logic [3:0]      r_stage;
  logic            r_conj;
  logic [DW-1:0]   r_dly [PIPE];

  logic            w_act;
  logic            w_go;
  logic            w_last_cnt;
  logic            w_last_drain;
  logic            w_last_stage;
  logic [W-1:0]    w_r;
  logic            w_m0;
  logic [TWW-1:0]  w_tw;
  logic [DW-1:0]   w_dly_out;

  assign w_act        = (r_state == S_READ) || (r_state == S_DRAIN);
  assign w_go         = w_act && !hold;
  assign w_last_cnt   = (r_cnt == '1);
  assign w_last_drain = (r_drain == DCW'(PIPE - 1));
  assign w_last_stage = (r_stage == 4'(NUMSTAGES - 1));
  assign w_dly_out    = r_dly[PIPE-1];

  // Variable rotate / bit-select / shift amounts are unrolled over the
  // stage number so every select is a constant index.
  always_comb begin
    w_r  = '0;
    w_m0 = 1'b0;
    w_tw = '0;
    for (int unsigned k = 0; k < W; k++) begin
      if ((32'(r_stage) % W) == k)
        w_r = W'(({r_cnt, r_cnt} << k) >> W);
    end
    for (int unsigned b = 0; b < W; b++) begin
      if (32'(r_stage) == b + 2)
        w_m0 = r_cnt[b];
    end
    for (int unsigned k = 0; k < NUMSTAGES; k++) begin
      if (32'(r_stage) == k)
        w_tw = TWW'({1'b0, r_cnt & W'((32'd1 << k) - 32'd1)} << (NUMSTAGES - 1 - k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    done       = 1'b0;
    rd_en      = 1'b0;
    stage_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_READ;
      end
      S_READ: begin
        rd_en = !hold;
        if (!hold && w_last_cnt) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!hold && w_last_drain) begin
          stage_done = 1'b1;
          w_next     = w_last_stage ? S_DONE : S_READ;
        end
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_drain <= '0;
      r_stage <= '0;
      r_conj  <= 1'b0;
      for (int unsigned i = 0; i < PIPE; i++) r_dly[i] <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_cnt   <= '0;
        r_drain <= '0;
        r_stage <= '0;
        r_conj  <= inverse;
      end
      if (w_go) begin
        for (int unsigned i = PIPE - 1; i > 0; i--) r_dly[i] <= r_dly[i-1];
        r_dly[0] <= (r_state == S_READ) ? {1'b1, w_r, w_m0} : '0;
        if (r_state == S_READ) begin
          r_cnt <= r_cnt + 1'b1;
        end else if (w_last_drain) begin
          r_drain <= '0;
          if (!w_last_stage) r_stage <= r_stage + 1'b1;
        end else begin
          r_drain <= r_drain + 1'b1;
        end
      end
    end
  end

  assign stage_num = r_stage;
  assign conj_en   = r_conj;
  assign rd_addr   = w_act ? {4{w_r}} : '0;
  assign m0_s      = w_act & w_m0;
  assign m1_s      = !w_act ? 2'd0 : (r_stage == 4'd0) ? 2'd0 : (r_stage == 4'd1) ? 2'd1 : 2'd2;
  assign tw_idx    = w_act ? w_tw : '0;
  assign wr_en     = w_go && w_dly_out[DW-1];
  assign wr_addr   = w_act ? {4{w_dly_out[W:1]}} : '0;
  assign m2_s      = w_act & w_dly_out[0];
  assign m3_s      = w_act & w_dly_out[0];

endmodule

// File: tb/tb_fft_seq_control.sv
// Bench for fft_seq_control: directed vector table, hand-written corner
// sequences and a randomized run against a progress-counter reference model.
module tb_fft_seq_control;

  localparam int NS   = 5;
  localparam int PIPE = 2;
  localparam int W    = NS - 2;
  localparam int C    = 1 << W;
  localparam int L    = C + PIPE;
  localparam int TOT  = NS * L;

  logic clk = 1'b0;
  logic rst, start, inverse, hold;
  logic busy, done, stage_done, conj_en, rd_en, wr_en, m0_s, m2_s, m3_s;
  logic [3:0]     stage_num;
  logic [1:0]     m1_s;
  logic [4*W-1:0] rd_addr, wr_addr;
  logic [NS-2:0]  tw_idx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;
  int done_cyc;
  int done_cnt;

  // Model: a transform is just "p unstalled cycles elapsed since first read".
  bit m_act, m_done, m_conj;
  int m_p, m_stage;

  typedef struct {
    int cyc; bit st; bit rd; bit wr; bit sd; bit dn; bit bz; int stg;
  } vec_t;
  vec_t vec[14];

  fft_seq_control #(.NUMSTAGES(NS), .PIPE(PIPE)) dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .hold(hold),
    .busy(busy), .done(done), .stage_done(stage_done), .stage_num(stage_num),
    .conj_en(conj_en), .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en),
    .wr_addr(wr_addr), .m0_s(m0_s), .m1_s(m1_s), .m2_s(m2_s), .m3_s(m3_s),
    .tw_idx(tw_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rotl(int x, int k);
    return ((x << k) | (x >> (W - k))) & (C - 1);
  endfunction

  function automatic int rep4(int r);
    return r | (r << W) | (r << (2 * W)) | (r << (3 * W));
  endfunction

  function automatic int m0f(int cnt, int s);
    return (s >= 2 && s - 2 < W) ? ((cnt >> (s - 2)) & 1) : 0;
  endfunction

  function automatic int twf(int cnt, int s);
    return ((cnt % (1 << s)) << (NS - 1 - s)) & ((1 << (NS - 1)) - 1);
  endfunction

  task automatic model_reset();
    m_act = 0; m_done = 0; m_conj = 0; m_p = 0; m_stage = 0;
  endtask

  task automatic model_check();
    int s, w, e_wa, e_m2;
    if (m_act) begin
      s = m_p / L;
      w = m_p % L;
      e_wa = 0; e_m2 = 0;
      if (w >= PIPE) begin
        e_wa = rep4(rotl(w - PIPE, s % W));
        e_m2 = m0f(w - PIPE, s);
      end
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("stage_num", stage_num, s);
      chk("rd_en", rd_en, (w < C) && !hold);
      chk("wr_en", wr_en, (w >= PIPE) && !hold);
      chk("stage_done", stage_done, (w == L - 1) && !hold);
      chk("wr_addr", wr_addr, e_wa);
      chk("m2_s", m2_s, e_m2);
      chk("m3_s", m3_s, e_m2);
      if (w < C) begin
        chk("rd_addr", rd_addr, rep4(rotl(w, s % W)));
        chk("m0_s", m0_s, m0f(w, s));
        chk("m1_s", m1_s, (s == 0) ? 0 : (s == 1) ? 1 : 2);
        chk("tw_idx", tw_idx, twf(w, s));
      end
    end else begin
      chk("busy", busy, m_done);
      chk("done", done, m_done);
      chk("stage_num", stage_num, m_stage);
      chk("rd_en", rd_en, 0);
      chk("wr_en", wr_en, 0);
      chk("stage_done", stage_done, 0);
      chk("rd_addr", rd_addr, 0);
      chk("wr_addr", wr_addr, 0);
      chk("sel", {m0_s, m1_s, m2_s, m3_s}, 0);
      chk("tw_idx", tw_idx, 0);
    end
    chk("conj_en", conj_en, m_conj);
  endtask

  task automatic model_advance();
    if (m_done) begin
      m_done = 0;
    end else if (!m_act) begin
      if (start) begin
        m_act = 1; m_p = 0; m_stage = 0; m_conj = inverse;
      end
    end else if (!hold) begin
      m_p++;
      m_stage = (m_p < TOT) ? m_p / L : NS - 1;
      if (m_p == TOT) begin
        m_act = 0; m_done = 1;
      end
    end
  endtask

  task automatic pre(input bit st, input bit inv, input bit hd);
    start = st; inverse = inv; hold = hd;
    @(negedge clk);
    model_check();
    if (done) begin
      done_cyc = cyc;
      done_cnt++;
    end
  endtask

  task automatic post();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec[0]  = '{0,  1, 0, 0, 0, 0, 0, 0};
    vec[1]  = '{1,  0, 1, 0, 0, 0, 1, 0};
    vec[2]  = '{2,  0, 1, 0, 0, 0, 1, 0};
    vec[3]  = '{3,  0, 1, 1, 0, 0, 1, 0};
    vec[4]  = '{8,  0, 1, 1, 0, 0, 1, 0};
    vec[5]  = '{9,  0, 0, 1, 0, 0, 1, 0};
    vec[6]  = '{10, 0, 0, 1, 1, 0, 1, 0};
    vec[7]  = '{11, 0, 1, 0, 0, 0, 1, 1};
    vec[8]  = '{20, 0, 0, 1, 1, 0, 1, 1};
    vec[9]  = '{30, 0, 0, 1, 1, 0, 1, 2};
    vec[10] = '{41, 0, 1, 0, 0, 0, 1, 4};
    vec[11] = '{50, 0, 0, 1, 1, 0, 1, 4};
    vec[12] = '{51, 0, 0, 0, 0, 1, 1, 4};
    vec[13] = '{52, 0, 0, 0, 0, 0, 0, 4};

    rst = 1'b1; start = 1'b0; inverse = 1'b0; hold = 1'b0;
    model_reset();
    cyc = 0; done_cnt = 0; done_cyc = -1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    pre(0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {done, stage_done, rd_en, wr_en, conj_en, m0_s, m2_s, m3_s}, 0);
    chk("rst_addr", {rd_addr, wr_addr, tw_idx, m1_s, stage_num}, 0);
    post();
    rst = 1'b0;

    // Full run, table-driven
    cyc = 0; done_cnt = 0;
    for (int c = 0; c < 54; c++) begin
      bit st;
      st = 0;
      for (int k = 0; k < 14; k++) if (vec[k].cyc == c) st = vec[k].st;
      pre(st, 0, 0);
      for (int k = 0; k < 14; k++) begin
        if (vec[k].cyc == c) begin
          chk("tbl_rd_en", rd_en, vec[k].rd);
          chk("tbl_wr_en", wr_en, vec[k].wr);
          chk("tbl_stage_done", stage_done, vec[k].sd);
          chk("tbl_done", done, vec[k].dn);
          chk("tbl_busy", busy, vec[k].bz);
          chk("tbl_stage_num", stage_num, vec[k].stg);
        end
      end
      if (c == 14) begin
        chk("rot_rd_addr", rd_addr, 12'hDB6);
        chk("rot_tw_idx", tw_idx, 8);
      end
      if (c == 16) chk("rot_wr_addr", wr_addr, 12'hDB6);
      post();
    end
    chk("full_done_cnt", done_cnt, 1);

    // Stall in stage 2 at cnt=4
    cyc = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 58; c++) begin
      pre(c == 0, 0, (c >= 25 && c <= 27));
      if (c >= 25 && c <= 27) begin
        chk("stall_rd_en", rd_en, 0);
        chk("stall_wr_en", wr_en, 0);
      end
      if (c == 28) chk("stall_resume_addr", rd_addr, 12'h492);
      post();
    end
    chk("stall_done_cyc", done_cyc, 54);
    chk("stall_done_cnt", done_cnt, 1);

    // Reset mid-run
    cyc = 0; done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      pre(c == 0, 0, 0);
      post();
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_en", {rd_en, wr_en, done, stage_done}, 0);
    chk("midrst_addr", {rd_addr, wr_addr, tw_idx}, 0);
    chk("midrst_stage", stage_num, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      pre(0, 0, 0);
      post();
    end
    chk("midrst_no_done", done_cnt, 0);
    cyc = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 56; c++) begin
      pre(c == 0, 0, 0);
      post();
    end
    chk("midrst_rerun_done", done_cyc, 51);

    // Inverse mode; starts while busy and in DONE are ignored
    cyc = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 56; c++) begin
      pre(c == 0 || c == 5 || c == 30 || c == 51, c == 0, 0);
      if (c == 51) chk("mode_conj_at_done", conj_en, 1);
      if (c == 52) chk("mode_idle_after_done", busy, 0);
      post();
    end
    chk("mode_done_cyc", done_cyc, 51);
    chk("mode_done_cnt", done_cnt, 1);
    pre(1, 0, 0);
    post();
    pre(0, 0, 0);
    chk("mode_conj_cleared", conj_en, 0);
    post();

    // Randomized start/inverse/hold against the model
    for (int c = 0; c < 1500; c++) begin
      pre($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0);
      post();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
